// File: rtl/div_pkg.sv
// Shared types and constants for the iterative integer divide unit.
package div_pkg;

    localparam int XLEN  = 32;
    localparam int TAG_W = 6;

    typedef enum logic [1:0] {
        OP_DIV  = 2'd0,
        OP_DIVU = 2'd1,
        OP_REM  = 2'd2,
        OP_REMU = 2'd3
    } div_op_t;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CALC     = 2'd1,
        S_WAIT_CDB = 2'd2
    } div_state_t;

    function automatic logic is_signed_op(input div_op_t op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic sgn);
        return (sgn && v[XLEN-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in a dividend bit, trial-subtract the divisor.
module div_step
    import div_pkg::*;
(
    input  logic [XLEN-1:0] rem_in,
    input  logic            dividend_bit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic            q_bit
);

    logic [XLEN:0] trial;
    logic [XLEN:0] diff;

    always_comb begin
        trial   = {rem_in, dividend_bit};
        diff    = trial - {1'b0, divisor};
        // rem_in < divisor keeps trial below 2*divisor, so the top bit is a clean borrow
        q_bit   = ~diff[XLEN];
        rem_out = q_bit ? diff[XLEN-1:0] : trial[XLEN-1:0];
    end

endmodule

// File: rtl/div_exec_unit.sv
// Iterative 32-cycle divide/remainder execution unit publishing results on the CDB.
// DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow skip CALC and publish next cycle.
//
// state      | meaning
// S_IDLE     | ready; accepts an issue when issue_valid is high
// S_CALC     | 32 restoring iterations on operand magnitudes
// S_WAIT_CDB | result held, cdb_req asserted until cdb_grant
module div_exec_unit
    import div_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [1:0]       issue_op,
    input  logic [XLEN-1:0]  issue_rs1_data,
    input  logic [XLEN-1:0]  issue_rs2_data,
    input  logic [TAG_W-1:0] issue_rd_tag,
    output logic             ex_done,
    output logic             busy,
    output logic             cdb_req,
    input  logic             cdb_grant,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [XLEN-1:0]  cdb_data,
    output logic             cdb_data_valid
);

    div_state_t       state, state_nxt;
    logic [5:0]       cnt;
    logic [XLEN-1:0]  quo_q, rem_q, dvs_q, result_q;
    logic [TAG_W-1:0] tag_q;
    logic             is_rem_q, neg_quo_q, neg_rem_q;

    div_op_t          op_in;
    logic             sgn_in;
    logic [XLEN-1:0]  step_rem, quo_final, calc_result;
    logic             step_bit;

    assign op_in  = div_op_t'(issue_op);
    assign sgn_in = is_signed_op(op_in);

`ifdef DIV_FAST_SPECIAL_EN
    logic            div_zero, sgn_ovf, special;
    logic [XLEN-1:0] special_result;

    always_comb begin
        div_zero = (issue_rs2_data == '0);
        sgn_ovf  = sgn_in && (issue_rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                          && (issue_rs2_data == '1);
        special  = div_zero || sgn_ovf;
        if (div_zero)
            special_result = issue_op[1] ? issue_rs1_data : '1;
        else
            special_result = issue_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
`endif

    div_step u_step (
        .rem_in       (rem_q),
        .dividend_bit (quo_q[XLEN-1]),
        .divisor      (dvs_q),
        .rem_out      (step_rem),
        .q_bit        (step_bit)
    );

    always_comb begin
        quo_final = {quo_q[XLEN-2:0], step_bit};
        if (is_rem_q)
            calc_result = neg_rem_q ? (~step_rem + 1'b1) : step_rem;
        else
            calc_result = neg_quo_q ? (~quo_final + 1'b1) : quo_final;
    end

    always_comb begin
        state_nxt = state;
        ex_done   = 1'b0;
        case (state)
            S_IDLE: begin
                if (issue_valid) begin
                    ex_done = 1'b1;
`ifdef DIV_FAST_SPECIAL_EN
                    state_nxt = special ? S_WAIT_CDB : S_CALC;
`else
                    state_nxt = S_CALC;
`endif
                end
            end
            S_CALC:     if (cnt == '0) state_nxt = S_WAIT_CDB;
            S_WAIT_CDB: if (cdb_grant) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
        if (rst) begin
            state_nxt = S_IDLE;
            ex_done   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            result_q  <= '0;
            tag_q     <= '0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && ex_done) begin
                quo_q     <= magnitude(issue_rs1_data, sgn_in);
                dvs_q     <= magnitude(issue_rs2_data, sgn_in);
                rem_q     <= '0;
                cnt       <= 6'(XLEN - 1);
                tag_q     <= issue_rd_tag;
                is_rem_q  <= issue_op[1];
                neg_quo_q <= sgn_in && (issue_rs1_data[XLEN-1] ^ issue_rs2_data[XLEN-1])
                                    && (issue_rs2_data != '0);
                neg_rem_q <= sgn_in && issue_rs1_data[XLEN-1];
`ifdef DIV_FAST_SPECIAL_EN
                if (special) result_q <= special_result;
`endif
            end else if (state == S_CALC) begin
                quo_q <= quo_final;
                rem_q <= step_rem;
                if (cnt == '0)
                    result_q <= calc_result;
                else
                    cnt <= cnt - 6'd1;
            end
        end
    end

    assign busy           = (state != S_IDLE);
    assign cdb_req        = (state == S_WAIT_CDB);
    assign cdb_tag        = cdb_req ? tag_q : '0;
    assign cdb_data       = cdb_req ? result_q : '0;
    assign cdb_data_valid = cdb_req && cdb_grant;

endmodule

// File: tb/tb_div_exec_unit.sv
// Directed scoreboard bench for div_exec_unit; expected latency follows DIV_FAST_SPECIAL_EN.
module tb_div_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [1:0]  issue_op;
    logic [31:0] issue_rs1_data, issue_rs2_data;
    logic [5:0]  issue_rd_tag;
    logic        ex_done, busy, cdb_req, cdb_grant, cdb_data_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;

    typedef struct {
        logic [5:0]  tag;
        logic [31:0] data;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    div_exec_unit dut (
        .clk            (clk),
        .rst            (rst),
        .issue_valid    (issue_valid),
        .issue_op       (issue_op),
        .issue_rs1_data (issue_rs1_data),
        .issue_rs2_data (issue_rs2_data),
        .issue_rd_tag   (issue_rd_tag),
        .ex_done        (ex_done),
        .busy           (busy),
        .cdb_req        (cdb_req),
        .cdb_grant      (cdb_grant),
        .cdb_tag        (cdb_tag),
        .cdb_data       (cdb_data),
        .cdb_data_valid (cdb_data_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            2'd0:    return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
            2'd1:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'd2:    return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_FAST_SPECIAL_EN
        logic special;
        special = (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return special ? 1 : 33;
`else
        return 33;
`endif
    endfunction

    // Called at a negedge with the unit idle; returns at a negedge with the unit idle again.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] tag, input int hold, input bit keep_valid);
        exp_t e;
        int   n;
        issue_valid    = 1'b1;
        issue_op       = op;
        issue_rs1_data = a;
        issue_rs2_data = b;
        issue_rd_tag   = tag;
        #1;
        check("ex_done_at_issue", 32'(ex_done), 32'd1);
        sb.push_back('{tag: tag, data: model(op, a, b), lat: latency(op, a, b)});
        @(negedge clk);
        n = 1;
        if (!keep_valid) issue_valid = 1'b0;
        while (cdb_req !== 1'b1 && n < 100) begin
            if (n == 1) check("busy_in_calc", 32'(busy), 32'd1);
            if (keep_valid) check("ex_done_blocked_calc", 32'(ex_done), 32'd0);
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        check("cdb_req_latency", 32'(n), 32'(e.lat));
        for (int i = 0; i < hold; i++) begin
            check("hold_req",     32'(cdb_req), 32'd1);
            check("hold_tag",     32'(cdb_tag), 32'(e.tag));
            check("hold_data",    cdb_data, e.data);
            check("hold_ex_done", 32'(ex_done), 32'd0);
            check("hold_valid",   32'(cdb_data_valid), 32'd0);
            @(negedge clk);
        end
        cdb_grant = 1'b1;
        #1;
        check("cdb_data_valid", 32'(cdb_data_valid), 32'd1);
        check("cdb_tag",        32'(cdb_tag), 32'(e.tag));
        check("cdb_data",       cdb_data, e.data);
        @(negedge clk);
        cdb_grant = 1'b0;
        #1;
        check("ex_done_after_grant", 32'(ex_done), 32'(keep_valid));
        check("busy_after_grant",    32'(busy), 32'd0);
        issue_valid = 1'b0;
    endtask

    initial begin
        bit   saw_valid;
        rst            = 1'b1;
        issue_valid    = 1'b0;
        issue_op       = 2'd0;
        issue_rs1_data = '0;
        issue_rs2_data = '0;
        issue_rd_tag   = '0;
        cdb_grant      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        issue_valid = 1'b1;
        #1;
        check("rst_ex_done",   32'(ex_done), 32'd0);
        check("rst_busy",      32'(busy), 32'd0);
        check("rst_cdb_req",   32'(cdb_req), 32'd0);
        check("rst_cdb_valid", 32'(cdb_data_valid), 32'd0);
        check("rst_cdb_tag",   32'(cdb_tag), 32'd0);
        check("rst_cdb_data",  cdb_data, 32'd0);
        issue_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        cdb_grant = 1'b1;
        #1;
        check("idle_grant_ignored", 32'(cdb_data_valid), 32'd0);
        @(negedge clk);
        cdb_grant = 1'b0;
        check("idle_grant_busy", 32'(busy), 32'd0);

        do_op(2'd1, 32'd100, 32'd7, 6'd5, 0, 1'b0);
        do_op(2'd2, -32'sd7, 32'd2, 6'd6, 0, 1'b0);
        do_op(2'd0, -32'sd7, 32'd2, 6'd7, 0, 1'b0);
        do_op(2'd0, 32'd5, 32'd0, 6'd8, 0, 1'b0);
        do_op(2'd3, 32'd5, 32'd0, 6'd9, 0, 1'b0);
        do_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 6'd10, 0, 1'b0);
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 6'd11, 0, 1'b0);
        do_op(2'd2, -32'sd9, 32'd0, 6'd12, 0, 1'b0);
        do_op(2'd1, 32'hFFFF_FFFF, 32'h0001_0003, 6'd13, 0, 1'b0);
        do_op(2'd2, 32'd7, -32'sd2, 6'd14, 0, 1'b0);
        do_op(2'd0, -32'sd8, -32'sd3, 6'd15, 0, 1'b0);
        do_op(2'd3, 32'hDEAD_BEEF, 32'h0000_1234, 6'd63, 0, 1'b0);
        do_op(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 6'd20, 0, 1'b0);
        do_op(2'd0, 32'd1000, 32'd33, 6'd42, 10, 1'b1);

        // Reset in the middle of CALC must discard the operation.
        issue_valid    = 1'b1;
        issue_op       = 2'd1;
        issue_rs1_data = 32'd1000;
        issue_rs2_data = 32'd3;
        issue_rd_tag   = 6'd33;
        #1;
        check("rst_test_ex_done", 32'(ex_done), 32'd1);
        @(negedge clk);
        issue_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("rst_test_busy_mid_calc", 32'(busy), 32'd1);
        rst       = 1'b1;
        cdb_grant = 1'b1;
        @(negedge clk);
        check("midrst_busy",    32'(busy), 32'd0);
        check("midrst_cdb_req", 32'(cdb_req), 32'd0);
        check("midrst_valid",   32'(cdb_data_valid), 32'd0);
        check("midrst_tag",     32'(cdb_tag), 32'd0);
        check("midrst_data",    cdb_data, 32'd0);
        check("midrst_ex_done", 32'(ex_done), 32'd0);
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cdb_data_valid === 1'b1 || cdb_req === 1'b1) saw_valid = 1'b1;
        end
        check("no_publish_after_rst", 32'(saw_valid), 32'd0);
        cdb_grant = 1'b0;
        @(negedge clk);

        do_op(2'd1, 32'd100, 32'd7, 6'd5, 0, 1'b0);
        do_op(2'd2, -32'sd100, 32'd7, 6'd1, 2, 1'b0);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
